// File: rtl/axi_lite_multi_fifo_pkg.sv
// rtl/axi_lite_multi_fifo_pkg.sv - register map, status/ctrl bit indices and response codes
package axi_lite_multi_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_THRESH = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_AFULL = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_UNF   = 4;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_CLR_UNF = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] pack_status(input logic [7:0] level, input logic unf,
                                              input logic ovf, input logic afull,
                                              input logic full, input logic empty);
    logic [31:0] s;
    s = '0;
    s[15:8]     = level;
    s[ST_UNF]   = unf;
    s[ST_OVF]   = ovf;
    s[ST_AFULL] = afull;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/axi_lite_multi_fifo_sync_fifo_ch.sv
// rtl/axi_lite_multi_fifo_sync_fifo_ch.sv - one FIFO channel: storage, level, sticky flags, peripheral pop
module sync_fifo_ch
  import axi_lite_multi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push_req,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop_req,
  input  logic                  i_flush,
  input  logic                  i_clr_ovf,
  input  logic                  i_clr_unf,
  input  logic                  i_thresh_we,
  input  logic [7:0]            i_thresh,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [7:0]            o_level,
  output logic [7:0]            o_thresh,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_ovf,
  output logic                  o_unf,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LONE = LW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [7:0]            r_thresh;
  logic                  r_ovf, r_unf, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_empty, w_full, w_push, w_pop;

  // full/empty come from the registered level, so a same-cycle pop never frees room for a push
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LEVEL);
  assign w_push  = i_push_req && !w_full && !i_flush;
  assign w_pop   = i_pop_req && !w_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_thresh <= 8'(FIFO_DEPTH - 1);
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PONE;
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PONE;
          r_rdata  <= r_mem[r_rd_ptr];
          r_rvalid <= 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LONE;
          2'b01:   r_level <= r_level - LONE;
          default: r_level <= r_level;
        endcase
      end
      if (i_push_req && w_full && !i_flush) r_ovf <= 1'b1;
      else if (i_clr_ovf)                   r_ovf <= 1'b0;
      if (i_pop_req && w_empty && !i_flush) r_unf <= 1'b1;
      else if (i_clr_unf)                   r_unf <= 1'b0;
      if (i_thresh_we) r_thresh <= i_thresh;
    end
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_level  = 8'(r_level);
  assign o_thresh = r_thresh;
  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_afull  = (8'(r_level) >= r_thresh) && (r_thresh != 8'd0);
  assign o_ovf    = r_ovf;
  assign o_unf    = r_unf;
  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/axi_lite_multi_fifo.sv
// rtl/axi_lite_multi_fifo.sv - AXI-Lite front end over NUM_CH independent peripheral-drained FIFOs
module axi_lite_multi_fifo
  import axi_lite_multi_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                         clk_axi,
  input  logic                         axi_reset_i,
  input  logic [ADDR_WIDTH-1:0]        axi_awaddr_i,
  input  logic                         axi_awvalid_i,
  output logic                         axi_awready_o,
  input  logic [DATA_WIDTH-1:0]        axi_wdata_i,
  input  logic [3:0]                   axi_wstrb_i,
  input  logic                         axi_wvalid_i,
  output logic                         axi_wready_o,
  output logic [1:0]                   axi_bresp_o,
  output logic                         axi_bvalid_o,
  input  logic                         axi_bready_i,
  input  logic [ADDR_WIDTH-1:0]        axi_araddr_i,
  input  logic                         axi_arvalid_i,
  output logic                         axi_arready_o,
  output logic [DATA_WIDTH-1:0]        axi_rdata_o,
  output logic [1:0]                   axi_rresp_o,
  output logic                         axi_rvalid_o,
  input  logic                         axi_rready_i,
  input  logic [NUM_CH-1:0]            periph_rd_en_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] periph_rdata_o,
  output logic [NUM_CH-1:0]            periph_rvalid_o,
  output logic [NUM_CH-1:0]            periph_empty_o,
  output logic [NUM_CH-1:0]            periph_full_o,
  output logic [NUM_CH-1:0]            periph_afull_o
);

  logic                  r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_wr_fire, w_rd_fire, w_wr_ch_ok, w_rd_ch_ok, w_wr_full;
  logic [1:0]            w_wr_ch, w_wr_reg, w_rd_ch, w_rd_reg, w_bresp, w_rresp;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [NUM_CH-1:0]     w_push_req, w_flush, w_clr_ovf, w_clr_unf, w_thresh_we;
  logic [NUM_CH-1:0]     w_empty, w_full, w_afull, w_ovf, w_unf;
  logic [DATA_WIDTH-1:0] w_head   [NUM_CH];
  logic [DATA_WIDTH-1:0] w_prdata [NUM_CH];
  logic [7:0]            w_level  [NUM_CH];
  logic [7:0]            w_thresh [NUM_CH];
  logic                  w_unused;

  assign w_unused   = ^{axi_awaddr_i, axi_araddr_i};
  assign w_wr_fire  = r_awready && axi_awvalid_i && axi_wvalid_i;
  assign w_rd_fire  = r_arready && axi_arvalid_i;
  assign w_wr_ch    = axi_awaddr_i[5:4];
  assign w_wr_reg   = axi_awaddr_i[3:2];
  assign w_rd_ch    = axi_araddr_i[5:4];
  assign w_rd_reg   = axi_araddr_i[3:2];
  assign w_wr_ch_ok = 3'(w_wr_ch) < 3'(NUM_CH);
  assign w_rd_ch_ok = 3'(w_rd_ch) < 3'(NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_sel;
    assign w_sel          = w_wr_fire && (w_wr_ch == 2'(c));
    assign w_push_req[c]  = w_sel && (w_wr_reg == REG_DATA) && (axi_wstrb_i == 4'hF);
    assign w_flush[c]     = w_sel && (w_wr_reg == REG_CTRL) && axi_wdata_i[CTRL_FLUSH];
    assign w_clr_ovf[c]   = w_sel && (w_wr_reg == REG_CTRL) && axi_wdata_i[CTRL_CLR_OVF];
    assign w_clr_unf[c]   = w_sel && (w_wr_reg == REG_CTRL) && axi_wdata_i[CTRL_CLR_UNF];
    assign w_thresh_we[c] = w_sel && (w_wr_reg == REG_THRESH) && axi_wstrb_i[0];

    sync_fifo_ch #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_ch (
      .clk(clk_axi), .rst(axi_reset_i),
      .i_push_req(w_push_req[c]), .i_wdata(axi_wdata_i), .i_pop_req(periph_rd_en_i[c]),
      .i_flush(w_flush[c]), .i_clr_ovf(w_clr_ovf[c]), .i_clr_unf(w_clr_unf[c]),
      .i_thresh_we(w_thresh_we[c]), .i_thresh(axi_wdata_i[7:0]),
      .o_head(w_head[c]), .o_level(w_level[c]), .o_thresh(w_thresh[c]),
      .o_empty(w_empty[c]), .o_full(w_full[c]), .o_afull(w_afull[c]),
      .o_ovf(w_ovf[c]), .o_unf(w_unf[c]), .o_rdata(w_prdata[c]), .o_rvalid(periph_rvalid_o[c])
    );

    assign periph_rdata_o[c*DATA_WIDTH +: DATA_WIDTH] = w_prdata[c];
  end

  always_comb begin
    w_wr_full = 1'b0;
    w_bresp   = RESP_OKAY;
    w_rresp   = RESP_OKAY;
    w_rdata   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_wr_ch == 2'(c)) w_wr_full = w_full[c];
      if (w_rd_ch == 2'(c)) begin
        case (w_rd_reg)
          REG_DATA:   if (w_empty[c]) w_rresp = RESP_SLVERR;
                      else            w_rdata = w_head[c];
          REG_STATUS: w_rdata = pack_status(w_level[c], w_unf[c], w_ovf[c],
                                            w_afull[c], w_full[c], w_empty[c]);
          REG_THRESH: w_rdata = {24'b0, w_thresh[c]};
          default:    w_rdata = '0;
        endcase
      end
    end
    if (!w_rd_ch_ok) begin
      w_rresp = RESP_SLVERR;
      w_rdata = '0;
    end
    if (!w_wr_ch_ok) w_bresp = RESP_SLVERR;
    else if (w_wr_reg == REG_DATA && (axi_wstrb_i != 4'hF || w_wr_full)) w_bresp = RESP_SLVERR;
  end

  // Ready is a registered single-cycle pulse; the transfer happens on the edge ending that pulse
  always_ff @(posedge clk_axi) begin
    if (axi_reset_i) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_awready <= axi_awvalid_i && axi_wvalid_i && !r_bvalid && !r_awready;
      r_arready <= axi_arvalid_i && !r_rvalid && !r_arready;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp;
      end else if (r_bvalid && axi_bready_i) begin
        r_bvalid <= 1'b0;
      end
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rresp;
        r_rdata  <= w_rdata;
      end else if (r_rvalid && axi_rready_i) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign axi_awready_o  = r_awready;
  assign axi_wready_o   = r_awready;
  assign axi_bvalid_o   = r_bvalid;
  assign axi_bresp_o    = r_bresp;
  assign axi_arready_o  = r_arready;
  assign axi_rvalid_o   = r_rvalid;
  assign axi_rresp_o    = r_rresp;
  assign axi_rdata_o    = r_rdata;
  assign periph_empty_o = w_empty;
  assign periph_full_o  = w_full;
  assign periph_afull_o = w_afull;

endmodule

// File: tb/tb_axi_lite_multi_fifo.sv
// tb/tb_axi_lite_multi_fifo.sv - directed scoreboard bench for axi_lite_multi_fifo
module tb_axi_lite_multi_fifo;
  localparam int AW = 6, DW = 32, DEPTH = 8, NCH = 4;
  localparam logic [1:0] OK = 2'b00, SE = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [AW-1:0]     awaddr = '0, araddr = '0;
  logic              awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [DW-1:0]     wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              bready = 1'b1, rready = 1'b1;
  logic [NCH-1:0]    rd_en = '0;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [DW-1:0]     rdata;
  logic [NCH*DW-1:0] p_rdata;
  logic [NCH-1:0]    p_rvalid, p_empty, p_full, p_afull;

  axi_lite_multi_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .clk_axi(clk), .axi_reset_i(rst),
    .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .periph_rd_en_i(rd_en), .periph_rdata_o(p_rdata), .periph_rvalid_o(p_rvalid),
    .periph_empty_o(p_empty), .periph_full_o(p_full), .periph_afull_o(p_afull)
  );

  int n_vec = 0, n_miss = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] exp_p[NCH][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL timeout %s: got no handshake expected one within 20 cycles", name);
  endtask

  always @(negedge clk) begin : monitor
    logic [33:0] e;
    if (!rst) begin
      if (bvalid) begin
        if (exp_b.size() == 0) check("unexpected_bvalid", 32'(bvalid), 32'd0);
        else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      if (rvalid) begin
        if (exp_r.size() == 0) check("unexpected_rvalid", 32'(rvalid), 32'd0);
        else begin
          e = exp_r.pop_front();
          check("rresp", 32'(rresp), 32'(e[33:32]));
          check("rdata", rdata, e[31:0]);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (p_rvalid[c]) begin
          if (exp_p[c].size() == 0) check("unexpected_periph_rvalid", 32'(p_rvalid[c]), 32'd0);
          else check("periph_rdata", p_rdata[c*DW +: DW], exp_p[c].pop_front());
        end
      end
    end
  end

  task automatic wait_flag(input string name, input int which);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (which == 0) ? awready : (which == 1) ? arready : (which == 2) ? bvalid : rvalid;
    end
    if (!got) timeout(name);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp);
    exp_b.push_back(resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_flag("awready", 0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    if (!bvalid) wait_flag("bvalid", 2);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [1:0] resp, input logic [31:0] d);
    exp_r.push_back({resp, d});
    araddr = a; arvalid = 1'b1;
    wait_flag("arready", 1);
    @(negedge clk);
    arvalid = 1'b0;
    if (!rvalid) wait_flag("rvalid", 3);
    @(negedge clk);
  endtask

  task automatic periph_pop(input int c, input bit has_data, input logic [31:0] d);
    if (has_data) exp_p[c].push_back(d);
    rd_en[c] = 1'b1;
    @(negedge clk);
    rd_en[c] = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    bit got;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_empty", 32'(p_empty), 32'hF);
    check("rst_full_afull", 32'({p_full, p_afull}), 32'd0);
    check("rst_periph_rdata", 32'(|p_rdata), 32'd0);

    // ch1: push two words, peek, pop in order
    axi_write(6'h10, 32'hDEADBEEF, 4'hF, OK);
    axi_write(6'h10, 32'hFEEDCAFE, 4'hF, OK);
    axi_read(6'h10, OK, 32'hDEADBEEF);
    axi_read(6'h14, OK, 32'h00000200);
    periph_pop(1, 1'b1, 32'hDEADBEEF);
    periph_pop(1, 1'b1, 32'hFEEDCAFE);
    check("periph_rdata_hold", p_rdata[1*DW +: DW], 32'hFEEDCAFE);
    axi_read(6'h14, OK, 32'h00000001);

    // ch0: fill, overflow, drain half
    for (int i = 0; i < DEPTH; i++) axi_write(6'h00, 32'h100 + 32'(i), 4'hF, OK);
    check("ch0_full_pin", 32'(p_full[0]), 32'd1);
    axi_write(6'h00, 32'h108, 4'hF, SE);
    axi_read(6'h04, OK, 32'h0000080E);
    axi_read(6'h24, OK, 32'h00000001);
    axi_write(6'h20, 32'h12345678, 4'h3, SE);
    axi_read(6'h24, OK, 32'h00000001);
    for (int i = 0; i < 4; i++) periph_pop(0, 1'b1, 32'h100 + 32'(i));

    // ch0: same-cycle push and pop at level 4
    exp_b.push_back(OK);
    exp_p[0].push_back(32'h104);
    awaddr = 6'h00; wdata = 32'h1AB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = awready;
    end
    if (!got) timeout("awready_pushpop");
    rd_en[0] = 1'b1;
    @(negedge clk);
    rd_en[0] = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    axi_read(6'h04, OK, 32'h00000408);
    axi_write(6'h0C, 32'h2, 4'hF, OK);
    axi_read(6'h04, OK, 32'h00000400);
    axi_read(6'h00, OK, 32'h105);

    // ch3: underflow and clear
    periph_pop(3, 1'b0, 32'h0);
    axi_read(6'h34, OK, 32'h00000011);
    axi_write(6'h3C, 32'h4, 4'hF, OK);
    axi_read(6'h34, OK, 32'h00000001);
    axi_read(6'h30, SE, 32'h0);
    axi_read(6'h3C, OK, 32'h0);

    // ch2: threshold and flush
    axi_write(6'h28, 32'h3, 4'hF, OK);
    axi_read(6'h28, OK, 32'h3);
    axi_write(6'h20, 32'hA, 4'hF, OK);
    axi_write(6'h20, 32'hB, 4'hF, OK);
    check("afull2_below", 32'(p_afull[2]), 32'd0);
    axi_write(6'h20, 32'hC, 4'hF, OK);
    check("afull2_at", 32'(p_afull[2]), 32'd1);
    axi_read(6'h24, OK, 32'h00000304);
    axi_write(6'h2C, 32'h1, 4'hF, OK);
    axi_read(6'h24, OK, 32'h00000001);
    check("afull2_flushed", 32'(p_afull[2]), 32'd0);

    // reset on the write handshake edge: abandoned
    awaddr = 6'h10; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = awready;
    end
    if (!got) timeout("awready_rst");
    rst = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_bvalid", 32'(bvalid), 32'd0);
    check("rst2_empty", 32'(p_empty), 32'hF);
    @(negedge clk);
    check("rst2_bvalid_after", 32'(bvalid), 32'd0);
    axi_read(6'h08, OK, 32'h7);
    axi_read(6'h04, OK, 32'h00000001);
    axi_read(6'h14, OK, 32'h00000001);

    repeat (3) @(negedge clk);
    check("exp_b_drained", 32'(exp_b.size()), 32'd0);
    check("exp_r_drained", 32'(exp_r.size()), 32'd0);
    for (int c = 0; c < NCH; c++) check("exp_p_drained", 32'(exp_p[c].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
